// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage in-order pipeline: load-use interlock,
// branch flush, data-memory wait/timeout FSM, operand forwarding and perf counters.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_x,
    input  logic [4:0]  rs2_x,
    input  logic [4:0]  rd_x,
    input  logic        memread_x,
    input  logic [4:0]  rd_m,
    input  logic        regwrite_m,
    input  logic [4:0]  rd_w,
    input  logic        regwrite_w,
    input  logic        redirect_x,
    input  logic        dmem_req_m,
    input  logic        dmem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_x,
    output logic        stall_m,
    output logic        kill_dx,
    output logic        kill_x,
    output logic        kill_w,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        fault,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [1:0]  state_dbg,
    output logic [7:0]  wait_cnt_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       fault_nxt;
    logic       load_use;
    logic       freeze;

    // Data memory handshake: dmem_req_m is the M-stage valid, dmem_ready the
    // memory's ready; an access completes in the cycle both are high, and the
    // request is held stable (pipeline frozen) until that cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            fault    <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        fault_nxt    = fault;
        case (state)
            RUN: begin
                if (dmem_req_m && !dmem_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt < TIMEOUT_C) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end else begin
                    state_nxt = FAULT;
                    fault_nxt = 1'b1;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    assign load_use = memread_x && (rd_x != 5'd0) && ((rd_x == rs1_d) || (rd_x == rs2_d));

    // Freeze drops in the same cycle dmem_ready arrives, so the stall length
    // equals the number of not-ready cycles.
    assign freeze = (state == RUN && dmem_req_m && !dmem_ready)
                 || (state == MEM_WAIT && !dmem_ready)
                 || (state == FAULT);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_x = 1'b0;
        stall_m = 1'b0;
        kill_dx = 1'b0;
        kill_x  = 1'b0;
        kill_w  = 1'b0;
        if (!reset_n) begin
            // all stall/kill held low during reset
        end else if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_x = 1'b1;
            stall_m = 1'b1;
            kill_w  = 1'b1;
        end else if (redirect_x) begin
            kill_dx = 1'b1;
            kill_x  = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            kill_x  = 1'b1;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        if (regwrite_m && rd_m != 5'd0 && rd_m == rs1_x) begin
            fwd_a = 2'b01;
        end else if (regwrite_w && rd_w != 5'd0 && rd_w == rs1_x) begin
            fwd_a = 2'b10;
        end
    end

    always_comb begin
        fwd_b = 2'b00;
        if (regwrite_m && rd_m != 5'd0 && rd_m == rs2_x) begin
            fwd_b = 2'b01;
        end else if (regwrite_w && rd_w != 5'd0 && rd_w == rs2_x) begin
            fwd_b = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stall_f && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (kill_dx && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end

    assign state_dbg    = state;
    assign wait_cnt_dbg = wait_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (TIMEOUT=4): hazards, priority,
// memory wait and timeout, reset, forwarding and counter saturation.
module tb_pipeline_ctrl;

    localparam logic [31:0] S_RUN = 32'd0;
    localparam logic [31:0] S_MW  = 32'd1;
    localparam logic [31:0] S_FLT = 32'd2;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w;
    logic        memread_x, regwrite_m, regwrite_w, redirect_x, dmem_req_m, dmem_ready;
    logic        stall_f, stall_d, stall_x, stall_m, kill_dx, kill_x, kill_w, fault;
    logic [1:0]  fwd_a, fwd_b, state_dbg;
    logic [15:0] stall_cycles, flush_count;
    logic [7:0]  wait_cnt_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_x(rs1_x), .rs2_x(rs2_x),
        .rd_x(rd_x), .memread_x(memread_x),
        .rd_m(rd_m), .regwrite_m(regwrite_m),
        .rd_w(rd_w), .regwrite_w(regwrite_w),
        .redirect_x(redirect_x), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x), .stall_m(stall_m),
        .kill_dx(kill_dx), .kill_x(kill_x), .kill_w(kill_w),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fault(fault),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Packs {stall_f,stall_d,stall_x,stall_m,kill_dx,kill_x,kill_w}
    function automatic logic [31:0] ctl();
        return {25'd0, stall_f, stall_d, stall_x, stall_m, kill_dx, kill_x, kill_w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_x = 0; rs2_x = 0; rd_x = 0; rd_m = 0; rd_w = 0;
        memread_x = 0; regwrite_m = 0; regwrite_w = 0; redirect_x = 0;
        dmem_req_m = 0; dmem_ready = 1;
    endtask

    task automatic drive_load_use(input logic redirect);
        memread_x = 1; rd_x = 5'd5; rs2_d = 5'd5; rs1_d = 5'd3; redirect_x = redirect;
    endtask

    task automatic apply_reset();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        step();
        step();
        check("rst_state", 32'(state_dbg), S_RUN);
        check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst_flush_count", 32'(flush_count), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Held in reset with hazards present: controls stay low, forwarding live.
        drive_load_use(1'b0);
        regwrite_m = 1; rd_m = 5'd7; rs1_x = 5'd7;
        #1;
        check("rst_ctl_gated", ctl(), 32'h00);
        check("rst_fwd_live", 32'(fwd_a), 32'd1);
        clear_inputs();
        reset_n = 1;
        #1;

        check("idle_ctl", ctl(), 32'h00);

        // Load-use on rs2_d
        drive_load_use(1'b0);
        #1;
        check("lu_ctl", ctl(), 32'h62);
        step();
        clear_inputs();
        #1;
        check("lu_one_cycle", ctl(), 32'h00);
        check("lu_stall_cycles", 32'(stall_cycles), 32'd1);

        // Load-use variants that must not stall
        memread_x = 1; rd_x = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        #1;
        check("lu_rd0", ctl(), 32'h00);
        memread_x = 0; rd_x = 5'd9; rs1_d = 5'd9;
        #1;
        check("lu_noload", ctl(), 32'h00);
        memread_x = 1;
        #1;
        check("lu_rs1", ctl(), 32'h62);
        clear_inputs();
        #1;

        // Redirect overrides load-use
        drive_load_use(1'b1);
        #1;
        check("redir_ctl", ctl(), 32'h06);
        step();
        clear_inputs();
        #1;
        check("redir_flush_count", 32'(flush_count), 32'd1);
        check("redir_stall_cycles", 32'(stall_cycles), 32'd1);

        // Memory wait: ready low 3 cycles then high
        apply_reset();
        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(i));
            redirect_x = (i == 1);
            #1;
            check("mw_freeze", ctl(), 32'h79);
            check("mw_stall_cnt", 32'(stall_cycles), exp_q.pop_front());
            step();
        end
        check("mw_state", 32'(state_dbg), S_MW);
        check("mw_wait_cnt", 32'(wait_cnt_dbg), 32'd3);
        redirect_x = 0;
        dmem_ready = 1;
        #1;
        check("mw_release", ctl(), 32'h00);
        step();
        dmem_req_m = 0;
        #1;
        check("mw_back_run", 32'(state_dbg), S_RUN);
        check("mw_stall_total", 32'(stall_cycles), 32'd3);

        // Timeout with TIMEOUT=4: fault after 5 frozen cycles
        apply_reset();
        dmem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("to_freeze", ctl(), 32'h79);
            check("to_no_fault_yet", 32'(fault), 32'd0);
            step();
        end
        check("to_fault", 32'(fault), 32'd1);
        check("to_state", 32'(state_dbg), S_FLT);
        dmem_req_m = 0; dmem_ready = 1;
        #1;
        check("to_freeze_persist", ctl(), 32'h79);
        step();
        check("to_fault_sticky", 32'(fault), 32'd1);
        check("to_stall_cycles", 32'(stall_cycles), 32'd6);
        reset_n = 0;
        #1;
        check("to_rst_gated", ctl(), 32'h00);
        step();
        reset_n = 1;
        #1;
        check("to_rst_state", 32'(state_dbg), S_RUN);
        check("to_rst_fault", 32'(fault), 32'd0);
        check("to_rst_stall", 32'(stall_cycles), 32'd0);
        check("to_rst_flush", 32'(flush_count), 32'd0);

        // Forwarding
        regwrite_m = 1; regwrite_w = 1; rd_m = 5'd7; rd_w = 5'd7; rs1_x = 5'd7; rs2_x = 5'd7;
        #1;
        check("fwd_a_m_prio", 32'(fwd_a), 32'd1);
        check("fwd_b_m_prio", 32'(fwd_b), 32'd1);
        rd_m = 5'd0;
        #1;
        check("fwd_a_w", 32'(fwd_a), 32'd2);
        rs1_x = 5'd0; rd_w = 5'd0;
        #1;
        check("fwd_a_none", 32'(fwd_a), 32'd0);
        rd_m = 5'd4; rs2_x = 5'd4; regwrite_m = 0;
        #1;
        check("fwd_b_nowrite", 32'(fwd_b), 32'd0);
        clear_inputs();

        // Saturation of stall_cycles
        drive_load_use(1'b0);
        repeat (65535) step();
        check("sat_reach", 32'(stall_cycles), 32'hFFFF);
        check("sat_still_stall", 32'(stall_f), 32'd1);
        step();
        check("sat_hold", 32'(stall_cycles), 32'hFFFF);
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, max data-memory wait cycles before fault (1..255; wait counter 8 bits).
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 rs1_d, rs2_d  in  5 each  source register addresses of the instruction in D.
REQ-006 rs1_x, rs2_x  in  5 each  source register addresses of the instruction in X.
REQ-007 rd_x, memread_x  in  5, 1  destination register and load flag of the instruction in X.
REQ-008 rd_m, regwrite_m  in  5, 1  destination register and write flag of the instruction in M.
REQ-009 rd_w, regwrite_w  in  5, 1  destination register and write flag of the instruction in W.
REQ-010 redirect_x  in  1  branch taken or jump resolved in X this cycle.
REQ-011 dmem_req_m, dmem_ready  in  1, 1  M-stage memory access valid; memory data/ack ready.
REQ-012 stall_f, stall_d, stall_x, stall_m  out  1 each  hold the F, F/D, D/X, X/M pipeline registers.
REQ-013 kill_dx  out  1  load NOP (PC 0, inst 0x00000013) into the F/D register.
REQ-014 kill_x, kill_w  out  1, 1  load a bubble into D/X, M/W registers.
REQ-015 fwd_a, fwd_b  out  2 each  X-stage operand select: 00 regfile, 01 from M, 10 from W.
REQ-016 fault  out  1  data-memory timeout, sticky until reset.
REQ-017 stall_cycles, flush_count  out  16 each  performance counters.

Function
REQ-018 FSM states RUN, MEM_WAIT, FAULT; 8-bit wait_cnt.
REQ-019 load_use = memread_x & (rd_x!=0) & (rd_x==rs1_d | rd_x==rs2_d).
REQ-020 freeze = (state==RUN & dmem_req_m & ~dmem_ready) | (state==MEM_WAIT & ~dmem_ready) | state==FAULT.
REQ-021 Priority, evaluated combinationally each cycle: freeze > redirect_x > load_use > none.
REQ-022 freeze: stall_f/d/x/m=1, kill_w=1, kill_dx=0, kill_x=0.
REQ-023 redirect_x (no freeze): kill_dx=1, kill_x=1, all stalls 0; load_use that same cycle is ignored.
REQ-024 load_use (no freeze, no redirect): stall_f=1, stall_d=1, kill_x=1, all other control outputs 0.
REQ-025 None active: all stall and kill outputs 0.
REQ-026 fwd_a=01 if regwrite_m & rd_m!=0 & rd_m==rs1_x; else 10 if regwrite_w & rd_w!=0 & rd_w==rs1_x; else 00; M has priority over W; fwd_b identical using rs2_x; forwarding is independent of the FSM.
REQ-027 RUN -> MEM_WAIT when dmem_req_m & ~dmem_ready; wait_cnt<=1.
REQ-028 MEM_WAIT -> RUN when dmem_ready; freeze deasserts in that same cycle.
REQ-029 MEM_WAIT & ~dmem_ready & wait_cnt<TIMEOUT: wait_cnt increments.
REQ-030 MEM_WAIT & ~dmem_ready & wait_cnt==TIMEOUT: -> FAULT, fault<=1.
REQ-031 FAULT is absorbing until reset; freeze stays asserted.
REQ-032 stall_cycles increments each cycle stall_f=1; saturates at 0xFFFF.
REQ-033 flush_count increments each cycle kill_dx=1; saturates at 0xFFFF.
REQ-034 Total stall duration for a single uninterrupted wait = cycles until dmem_ready, bounded by TIMEOUT+1.

Reset
REQ-035 reset_n=0 at a rising edge: state=RUN, wait_cnt=0, fault=0, stall_cycles=0, flush_count=0; overrides all other inputs, including mid-MEM_WAIT and in FAULT.
REQ-036 While reset_n=0, all stall and kill outputs are driven 0 irrespective of inputs; fwd_a/fwd_b remain combinational.

Verification
REQ-037 memread_x=1, rd_x=5, rs2_d=5 for one cycle -> stall_f=stall_d=kill_x=1 for 1 cycle; stall_cycles 0->1.
REQ-038 Same as REQ-037 plus redirect_x=1 -> kill_dx=kill_x=1, stall_f=0; flush_count 0->1.
REQ-039 dmem_req_m=1, dmem_ready low 3 cycles then high -> freeze for 3 cycles, state RUN on cycle 4, stall_cycles=3.
REQ-040 TIMEOUT=4, dmem_ready held 0 -> fault=1 after 5 frozen cycles, freeze persists; reset_n=0 one edge -> RUN, all counters 0.
REQ-041 regwrite_m=regwrite_w=1, rd_m=rd_w=rs1_x=7 -> fwd_a=01; rd_m=0 -> fwd_a=10; rs1_x=0 with rd_w=0 -> fwd_a=00.
REQ-042 Force stall_cycles to 0xFFFF via long load_use stream -> stays 0xFFFF on next stall cycle.
